// File: rtl/l2_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter_pkg
//   Shared definitions for the L2 port arbiter and its statistics block.
//   - arb_state_t : arbiter FSM states (IDLE, BUSY, DONE)
//   - REQ_I/REQ_D : requester ids (instruction side, data side)
//   - BLOCK_BITS  : width of a whole cache block bus
// ---------------------------------------------------------------------------
package l2_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    function automatic int BLOCK_BITS(input int block_size, input int data_width);
        return block_size * data_width;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_stats.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter_stats
//   Saturating event counters for the L2 port arbiter. Only built when
//   L2_PORT_ARBITER_STATS_EN is defined.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     grant_valid     : a grant is issued this cycle
//     grant_id        : requester receiving that grant
//     conflict        : both requesters active in an IDLE cycle
//     stat_grant0/1   : grants issued to requester 0 / 1
//     stat_conflict   : contended IDLE cycles
// ---------------------------------------------------------------------------
`ifdef L2_PORT_ARBITER_STATS_EN
module l2_port_arbiter_stats
    import l2_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        grant_valid,
    input  logic        grant_id,
    input  logic        conflict,
    output logic [31:0] stat_grant0,
    output logic [31:0] stat_grant1,
    output logic [31:0] stat_conflict
);

    // Counters stick at all-ones rather than wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (grant_valid && grant_id == REQ_I) stat_grant0 <= sat_inc(stat_grant0);
            if (grant_valid && grant_id == REQ_D) stat_grant1 <= sat_inc(stat_grant1);
            if (conflict)                         stat_conflict <= sat_inc(stat_conflict);
        end
    end

endmodule
`endif

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//   Shares one L2 cache port between the I-side (requester 0) and D-side
//   (requester 1) L1 caches. One requester is granted at a time, round-robin
//   on contention; the grant is held until the L2 signals l2_ready.
//   Optional feature macro: L2_PORT_ARBITER_STATS_EN adds grant/conflict
//   counters on ports stat_grant0, stat_grant1, stat_conflict.
//   Ports:
//     clk, rst                  : clock, synchronous active-high reset
//     reqN_addr/read/write/wdata: requester command, held until reqN_ready
//     reqN_rdata/hit/ready      : completion data, hit flag, 1-cycle pulse
//     l2_addr/data_out/read/write: registered L2 command
//     l2_data_in/ready/hit      : L2 response
// ---------------------------------------------------------------------------
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [ADDR_WIDTH-1:0]                         req0_addr,
    input  logic                                          req0_read,
    input  logic                                          req0_write,
    input  logic [BLOCK_BITS(BLOCK_SIZE, DATA_WIDTH)-1:0] req0_wdata,
    output logic [BLOCK_BITS(BLOCK_SIZE, DATA_WIDTH)-1:0] req0_rdata,
    output logic                                          req0_ready,
    output logic                                          req0_hit,
    input  logic [ADDR_WIDTH-1:0]                         req1_addr,
    input  logic                                          req1_read,
    input  logic                                          req1_write,
    input  logic [BLOCK_BITS(BLOCK_SIZE, DATA_WIDTH)-1:0] req1_wdata,
    output logic [BLOCK_BITS(BLOCK_SIZE, DATA_WIDTH)-1:0] req1_rdata,
    output logic                                          req1_ready,
    output logic                                          req1_hit,
    output logic [ADDR_WIDTH-1:0]                         l2_addr,
    output logic [BLOCK_BITS(BLOCK_SIZE, DATA_WIDTH)-1:0] l2_data_out,
    output logic                                          l2_read,
    output logic                                          l2_write,
    input  logic [BLOCK_BITS(BLOCK_SIZE, DATA_WIDTH)-1:0] l2_data_in,
    input  logic                                          l2_ready,
    input  logic                                          l2_hit
`ifdef L2_PORT_ARBITER_STATS_EN
    ,
    output logic [31:0]                                   stat_grant0,
    output logic [31:0]                                   stat_grant1,
    output logic [31:0]                                   stat_conflict
`endif
);

    arb_state_t state, next_state;
    logic       grant;       // requester owning the in-flight transaction
    logic       last_grant;  // most recent winner, loses the next tie
    logic       req0_active, req1_active;
    logic       do_grant, do_complete;
    logic       win_id, win_write;

    assign req0_active = req0_read | req0_write;
    assign req1_active = req1_read | req1_write;
    // Write takes priority when a requester raises both strobes.
    assign win_write   = (win_id == REQ_D) ? req1_write : req0_write;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        do_grant    = 1'b0;
        do_complete = 1'b0;
        win_id      = REQ_I;
        unique case (state)
            IDLE: begin
                if (req0_active || req1_active) begin
                    do_grant   = 1'b1;
                    next_state = BUSY;
                    if (req0_active && req1_active) win_id = ~last_grant;
                    else                            win_id = req1_active ? REQ_D : REQ_I;
                end
            end
            BUSY: begin
                if (l2_ready) begin
                    do_complete = 1'b1;
                    next_state  = DONE;
                end
            end
            // Gives the served requester one cycle to drop its request so it
            // is not granted a second time on a stale level.
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the wide rdata/wdata block registers are reset as well, because a
    // requester may look at them before its first completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= REQ_I;
            last_grant  <= REQ_D;
            l2_addr     <= '0;
            l2_data_out <= '0;
            l2_read     <= 1'b0;
            l2_write    <= 1'b0;
            req0_rdata  <= '0;
            req0_hit    <= 1'b0;
            req0_ready  <= 1'b0;
            req1_rdata  <= '0;
            req1_hit    <= 1'b0;
            req1_ready  <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            if (do_grant) begin
                grant       <= win_id;
                last_grant  <= win_id;
                l2_addr     <= (win_id == REQ_D) ? req1_addr  : req0_addr;
                l2_data_out <= (win_id == REQ_D) ? req1_wdata : req0_wdata;
                l2_write    <= win_write;
                l2_read     <= ~win_write;
            end
            if (do_complete) begin
                l2_read  <= 1'b0;
                l2_write <= 1'b0;
                l2_addr  <= '0;
                if (grant == REQ_D) begin
                    req1_rdata <= l2_data_in;
                    req1_hit   <= l2_hit;
                    req1_ready <= 1'b1;
                end else begin
                    req0_rdata <= l2_data_in;
                    req0_hit   <= l2_hit;
                    req0_ready <= 1'b1;
                end
            end
        end
    end

`ifdef L2_PORT_ARBITER_STATS_EN
    logic conflict;
    assign conflict = (state == IDLE) && req0_active && req1_active;

    l2_port_arbiter_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .grant_valid   (do_grant),
        .grant_id      (win_id),
        .conflict      (conflict),
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
    );
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_port_arbiter
//   Self-checking bench for l2_port_arbiter. A transaction-level model keeps
//   the pending request of each requester, the round-robin winner history and
//   the last completion data per requester; the bench plays the L2 side with
//   a chosen latency and compares every DUT-visible result to the model.
//   Stats checks are compiled only with L2_PORT_ARBITER_STATS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BS = 16;
    localparam int BB = BS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_read, req0_write, req1_read, req1_write;
    logic [BB-1:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
    logic          req0_ready, req0_hit, req1_ready, req1_hit;
    logic [AW-1:0] l2_addr;
    logic [BB-1:0] l2_data_out, l2_data_in;
    logic          l2_read, l2_write, l2_ready, l2_hit;
`ifdef L2_PORT_ARBITER_STATS_EN
    logic [31:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_addr   (req0_addr),
        .req0_read   (req0_read),
        .req0_write  (req0_write),
        .req0_wdata  (req0_wdata),
        .req0_rdata  (req0_rdata),
        .req0_ready  (req0_ready),
        .req0_hit    (req0_hit),
        .req1_addr   (req1_addr),
        .req1_read   (req1_read),
        .req1_write  (req1_write),
        .req1_wdata  (req1_wdata),
        .req1_rdata  (req1_rdata),
        .req1_ready  (req1_ready),
        .req1_hit    (req1_hit),
        .l2_addr     (l2_addr),
        .l2_data_out (l2_data_out),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_data_in  (l2_data_in),
        .l2_ready    (l2_ready),
        .l2_hit      (l2_hit)
`ifdef L2_PORT_ARBITER_STATS_EN
        ,
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [BB-1:0] wdata;
    } req_t;

    // Reference model state
    req_t          pend_req [2];
    bit            pending  [2];
    logic [BB-1:0] exp_rdata[2];
    bit            exp_hit  [2];
    int            model_last;   // last winner; reset value 1
    int            last_winner;

    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] cmd_addr;     // L2 command observed right after the grant
    logic [BB-1:0] cmd_data;

    task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BB-1:0] rand_block();
        logic [BB-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    function automatic req_t mk_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                                    input logic [BB-1:0] d);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // Kind 0: read only, 1: write only, 2: both strobes (write must win).
    function automatic req_t rand_req();
        int k;
        k = $urandom_range(0, 2);
        return mk_req(k != 1, k != 0, $urandom, rand_block());
    endfunction

    function automatic logic ready_of(input int i);
        return (i == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic drive_port(input int i, input bit rd, input bit wr,
                              input logic [AW-1:0] a, input logic [BB-1:0] d);
        if (i == 0) begin
            req0_read = rd; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_read = rd; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 2; i++) begin
            if (pending[i]) drive_port(i, pend_req[i].rd, pend_req[i].wr, pend_req[i].addr, pend_req[i].wdata);
            else            drive_port(i, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        pending[0] = 1'b0; pending[1] = 1'b0;
        apply_inputs();
        l2_ready = 1'b0; l2_hit = 1'b0; l2_data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_hit[0]   = 1'b0; exp_hit[1]  = 1'b0;
    endtask

    // Called at a negedge with inputs applied and the DUT in IDLE. Covers
    // the grant edge, lat BUSY cycles with l2_ready low, and the completion
    // edge. Returns at the negedge following completion.
    task automatic serve(input int lat, input bit noise, input bit drop,
                         input logic [BB-1:0] data, input bit hit);
        int w, o;
        bit exp_wr;
        logic [AW-1:0] ea;
        logic [BB-1:0] ed;
        if (pending[0] && pending[1]) w = (model_last == 0) ? 1 : 0;
        else                          w = pending[1] ? 1 : 0;
        o = 1 - w;
        model_last  = w;
        last_winner = w;
        exp_wr = pend_req[w].wr;
        ea     = pend_req[w].addr;
        ed     = pend_req[w].wdata;

        @(negedge clk);
        cmd_addr = l2_addr;
        cmd_data = l2_data_out;
        check("cmd_read",  l2_read,     !exp_wr);
        check("cmd_write", l2_write,    exp_wr);
        check("cmd_addr",  l2_addr,     ea);
        check("cmd_wdata", l2_data_out, ed);

        for (int k = 0; k < lat; k++) begin
            l2_ready = 1'b0; l2_data_in = rand_block(); l2_hit = 1'($urandom_range(0, 1));
            if (noise && !pending[o])
                drive_port(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rand_block());
            if (drop && k == 0) drive_port(w, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            check("busy_read",  l2_read,     !exp_wr);
            check("busy_write", l2_write,    exp_wr);
            check("busy_addr",  l2_addr,     ea);
            check("busy_wdata", l2_data_out, ed);
            check("busy_rdy0",  req0_ready,  1'b0);
            check("busy_rdy1",  req1_ready,  1'b0);
        end

        l2_ready = 1'b1; l2_data_in = data; l2_hit = hit;
        @(negedge clk);
        exp_rdata[w] = data;
        exp_hit[w]   = hit;
        check("cpl_rdy_win",   ready_of(w), 1'b1);
        check("cpl_rdy_other", ready_of(o), 1'b0);
        check("cpl_rdata0",    req0_rdata,  exp_rdata[0]);
        check("cpl_rdata1",    req1_rdata,  exp_rdata[1]);
        check("cpl_hit0",      req0_hit,    exp_hit[0]);
        check("cpl_hit1",      req1_hit,    exp_hit[1]);
        check("cpl_l2_read",   l2_read,     1'b0);
        check("cpl_l2_write",  l2_write,    1'b0);
        check("cpl_l2_addr",   l2_addr,     '0);
        pending[w] = 1'b0;
        // Stray response activity during DONE must be ignored.
        l2_ready = 1'($urandom_range(0, 1)); l2_data_in = rand_block(); l2_hit = 1'($urandom_range(0, 1));
    endtask

    // The DONE cycle: no grant even though requests may be asserted.
    task automatic done_cycle();
        @(negedge clk);
        check("done_no_read",  l2_read,    1'b0);
        check("done_no_write", l2_write,   1'b0);
        check("done_rdy0",     req0_ready, 1'b0);
        check("done_rdy1",     req1_ready, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            l2_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_read",  l2_read,    1'b0);
            check("idle_write", l2_write,   1'b0);
            check("idle_rdy0",  req0_ready, 1'b0);
            check("idle_rdy1",  req1_ready, 1'b0);
        end
    endtask

    initial begin
        logic [BB-1:0] blk;
        int n_conf, n_g0, n_g1;

        reset_dut();

        // Reset state
        check("rst_l2_read",  l2_read,     1'b0);
        check("rst_l2_write", l2_write,    1'b0);
        check("rst_l2_addr",  l2_addr,     '0);
        check("rst_l2_data",  l2_data_out, '0);
        check("rst_rdy0",     req0_ready,  1'b0);
        check("rst_rdy1",     req1_ready,  1'b0);
        check("rst_hit0",     req0_hit,    1'b0);
        check("rst_hit1",     req1_hit,    1'b0);
        check("rst_rdata0",   req0_rdata,  '0);
        check("rst_rdata1",   req1_rdata,  '0);

        // Single read, L2 answers after 4 BUSY cycles
        pend_req[0] = mk_req(1'b1, 1'b0, 32'h0000_1040, '0);
        pending[0]  = 1'b1;
        apply_inputs();
        blk = '0;
        blk[31:0] = 32'hDEAD_BEEF;
        serve(4, 1'b0, 1'b0, blk, 1'b1);
        check("sr_addr",  cmd_addr,         32'h0000_1040);
        check("sr_word0", req0_rdata[31:0], 32'hDEAD_BEEF);
        check("sr_hit",   req0_hit,         1'b1);
        apply_inputs();
        done_cycle();

        // Simultaneous reads: req0 first, then alternation
        reset_dut();
        pend_req[0] = mk_req(1'b1, 1'b0, 32'h100, rand_block());
        pend_req[1] = mk_req(1'b1, 1'b0, 32'h200, rand_block());
        pending[0] = 1'b1; pending[1] = 1'b1;
        apply_inputs();
        serve(1, 1'b0, 1'b0, rand_block(), 1'b0);
        check("sim1_addr", cmd_addr, 32'h100);
        pend_req[0] = mk_req(1'b1, 1'b0, 32'h104, rand_block());
        pending[0] = 1'b1;
        apply_inputs();
        done_cycle();
        serve(2, 1'b0, 1'b0, rand_block(), 1'b1);
        check("sim2_addr", cmd_addr, 32'h200);
        pend_req[1] = mk_req(1'b1, 1'b0, 32'h204, rand_block());
        pending[1] = 1'b1;
        apply_inputs();
        done_cycle();
        serve(0, 1'b0, 1'b0, rand_block(), 1'b0);
        check("sim3_addr", cmd_addr, 32'h104);
        apply_inputs();
        done_cycle();
        serve(1, 1'b0, 1'b0, rand_block(), 1'b1);
        check("sim4_addr", cmd_addr, 32'h204);
        apply_inputs();
        done_cycle();

        // Write from the D side
        blk = rand_block();
        blk[3*DW +: DW] = 32'h1234_5678;
        pend_req[1] = mk_req(1'b0, 1'b1, 32'h0000_3000, blk);
        pending[1]  = 1'b1;
        apply_inputs();
        serve(3, 1'b0, 1'b0, rand_block(), 1'b1);
        check("wr_word3", cmd_data[3*DW +: DW], 32'h1234_5678);
        apply_inputs();
        done_cycle();

        // Stability: 20 BUSY cycles with req1 toggling
        pend_req[0] = mk_req(1'b1, 1'b0, 32'h0000_5000, rand_block());
        pending[0]  = 1'b1;
        apply_inputs();
        serve(20, 1'b1, 1'b0, rand_block(), 1'b0);
        apply_inputs();
        done_cycle();

        // Randomized rounds
        for (int r = 0; r < 80; r++) begin
            if (!pending[0] && !pending[1]) begin
                int i;
                i = $urandom_range(0, 1);
                pend_req[i] = rand_req();
                pending[i]  = 1'b1;
            end
            apply_inputs();
            serve($urandom_range(0, 6), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  rand_block(), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pend_req[i] = rand_req();
                    pending[i]  = 1'b1;
                end
            end
            apply_inputs();
            done_cycle();
            if (!pending[0] && !pending[1]) idle_cycles($urandom_range(0, 3));
        end

        // Mid-transaction reset
        pend_req[0] = mk_req(1'b1, 1'b0, 32'h0000_7000, rand_block());
        pending[0] = 1'b1; pending[1] = 1'b0;
        apply_inputs();
        l2_ready = 1'b0;
        @(negedge clk);
        check("mr_busy", l2_read, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pending[0] = 1'b0;
        apply_inputs();
        model_last = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_hit[0]   = 1'b0; exp_hit[1]  = 1'b0;
        check("mr_read",   l2_read,    1'b0);
        check("mr_write",  l2_write,   1'b0);
        check("mr_addr",   l2_addr,    '0);
        check("mr_rdata0", req0_rdata, '0);
        l2_ready = 1'b1; l2_data_in = rand_block(); l2_hit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mr_late_rdy0", req0_ready, 1'b0);
            check("mr_late_rdy1", req1_ready, 1'b0);
            check("mr_late_read", l2_read,    1'b0);
        end
        // Arbiter is in IDLE: a fresh request is granted on the next edge.
        pend_req[1] = mk_req(1'b1, 1'b0, 32'h0000_7100, rand_block());
        pending[1]  = 1'b1;
        apply_inputs();
        serve(1, 1'b0, 1'b0, rand_block(), 1'b1);
        apply_inputs();
        done_cycle();

`ifdef L2_PORT_ARBITER_STATS_EN
        // Three contended rounds counted from a fresh reset
        reset_dut();
        n_conf = 0; n_g0 = 0; n_g1 = 0;
        pending[0] = 1'b1; pending[1] = 1'b1;
        pend_req[0] = rand_req();
        pend_req[1] = rand_req();
        for (int r = 0; r < 3; r++) begin
            apply_inputs();
            if (pending[0] && pending[1]) n_conf++;
            serve($urandom_range(0, 3), 1'b0, 1'b0, rand_block(), 1'b0);
            if (last_winner == 0) n_g0++; else n_g1++;
            if (r < 2) begin
                pend_req[last_winner] = rand_req();
                pending[last_winner]  = 1'b1;
            end else begin
                pending[0] = 1'b0; pending[1] = 1'b0;
            end
            apply_inputs();
            done_cycle();
        end
        idle_cycles(2);
        check("st_conflict", stat_conflict, n_conf);
        check("st_conf_min", (stat_conflict >= 3), 1'b1);
        check("st_grant0",   stat_grant0, n_g0);
        check("st_grant1",   stat_grant1, n_g1);
        check("st_sum",      stat_grant0 + stat_grant1, n_g0 + n_g1);
`else
        n_conf = 0; n_g0 = 0; n_g1 = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Two-requester arbiter that shares the single L2 cache port between the instruction-side and data-side L1 caches. It sits between both L1 cache instances and the L2 cache. Each L1 sees an L2-like port: it holds a level request until `ready` pulses. The arbiter grants one requester at a time, round-robin on contention, and holds the grant until the L2 transaction completes.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, word width.
- `BLOCK_SIZE`, 16, words per cache block; block bus width is BLOCK_SIZE*DATA_WIDTH.
- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_addr` / `req1_addr` input ADDR_WIDTH: requester address (0 = I-side, 1 = D-side).
- `req0_read` / `req1_read` input 1: read request, held high until the matching `ready`.
- `req0_write` / `req1_write` input 1: write (write-back) request, held high until the matching `ready`.
- `req0_wdata` / `req1_wdata` input BLOCK_SIZE*DATA_WIDTH: block to write.
- `req0_rdata` / `req1_rdata` output BLOCK_SIZE*DATA_WIDTH: block returned by L2.
- `req0_ready` / `req1_ready` output 1: one-cycle completion pulse.
- `req0_hit` / `req1_hit` output 1: L2 hit flag for the completed transaction.
- `l2_addr` output ADDR_WIDTH; `l2_data_out` output BLOCK_SIZE*DATA_WIDTH; `l2_read` output 1; `l2_write` output 1: L2 command, all registered.
- `l2_data_in` input BLOCK_SIZE*DATA_WIDTH; `l2_ready` input 1; `l2_hit` input 1: L2 response.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE:** evaluate `reqN_active = reqN_read | reqN_write`.
  - If neither requester is active, stay in IDLE.
  - If only one is active, grant it.
  - If both are active, grant the requester not equal to `last_grant`.
  - On grant, register the winner's addr and wdata onto `l2_addr` and `l2_data_out`. Set `l2_write` if the winner's write is high, otherwise set `l2_read`. Write wins if both are high.
  - Record `grant` and `last_grant`, then go to BUSY.
- **BUSY:** hold all `l2_*` outputs stable. Ignore changes on the requester inputs.
  - When `l2_ready` is seen, register `l2_data_in` into the granted `reqN_rdata` and `l2_hit` into the granted `reqN_hit`.
  - Pulse the granted `reqN_ready` high for one cycle.
  - Clear `l2_read`, `l2_write` and `l2_addr` to 0, then go to DONE.
- **DONE:** wait one cycle for the served requester to drop its request, then return to IDLE. No new grant is made in DONE.
- `reqN_rdata` and `reqN_hit` hold their last values until the next completion for that requester. The ungranted requester's outputs are never disturbed.
- `last_grant` resets to 1, so requester 0 wins the first contention.

## Timing
- Reset values:
  - FSM state is IDLE and `last_grant` is 1.
  - `l2_read`, `l2_write`, `l2_addr`, `l2_data_out` are all 0.
  - `req*_ready`, `req*_hit`, `req*_rdata` are all 0.
- Request to L2 command: the request is sampled in IDLE at edge t, and `l2_read`/`l2_write` is high after edge t.
- L2 ready to requester ready: `l2_ready` is sampled at edge u, and `reqN_ready` is high from u to u+1.
- Minimum transaction length is 3 cycles when `l2_ready` returns on the first BUSY cycle.
- An `l2_ready` that arrives with `l2_ready` already high on entry to BUSY completes on that first BUSY edge.
- Back-to-back: with both requesters pending, the second grant is issued in the IDLE cycle right after DONE.
- `l2_ready` while in IDLE or DONE is ignored.
- A requester dropping its request mid-BUSY does not abort the L2 transaction; the ready pulse is still issued.
- `rst` asserted in any state returns to IDLE within one edge. It drops `l2_read`/`l2_write` immediately and discards any in-flight response.

## Configuration
- Macro: `L2_PORT_ARBITER_STATS_EN`.
- **Defined:** adds 32-bit saturating counters, readable as outputs `stat_grant0`, `stat_grant1` and `stat_conflict`, all reset to 0.
  - `stat_grant0` / `stat_grant1` count grants issued to each requester.
  - `stat_conflict` counts IDLE cycles in which both requesters were active.
- **Undefined:** the counters and their ports are absent, and behaviour is otherwise identical.

## Structure
- Shared package `l2_port_arbiter_pkg`:
  - state enum `arb_state_t` (IDLE, BUSY, DONE);
  - requester id constants `REQ_I` = 0 and `REQ_D` = 1;
  - block-bus width helper `BLOCK_BITS` = BLOCK_SIZE*DATA_WIDTH.
- One sub-module, `l2_port_arbiter_stats`, holds the counters. It is instantiated only under `L2_PORT_ARBITER_STATS_EN`.

## Test plan
- **Single read:** reset, then req0_read with addr 0x0000_1040; L2 returns block with word0 = 0xDEAD_BEEF and hit = 1 after 4 cycles.
  - `l2_read` is high with `l2_addr` = 0x1040.
  - `req0_ready` pulses once, `req0_rdata` word0 = 0xDEAD_BEEF, `req0_hit` = 1.
  - `req1_ready` never pulses.
- **Simultaneous reads** after reset with req0 at 0x100 and req1 at 0x200:
  - the first L2 command goes to 0x100 and the second to 0x200;
  - with both re-requesting afterwards, the third grant goes to req1's successor... no: the third grant goes to req0 (alternation).
- **Write:** req1_write with wdata word3 = 0x1234_5678.
  - `l2_write` = 1, `l2_read` = 0, `l2_data_out` word3 = 0x1234_5678.
  - `req1_ready` pulses after `l2_ready`.
- **Stability:** hold `l2_ready` low for 20 cycles in BUSY while toggling req1.
  - `l2_addr` and `l2_read` stay constant.
  - No ready pulse is issued before `l2_ready`.
- **Mid-transaction reset:** assert `rst` during BUSY.
  - The next cycle shows IDLE with `l2_read` = 0.
  - A late `l2_ready` produces no `req*_ready`.
- **Stats (`L2_PORT_ARBITER_STATS_EN`):** 3 contended rounds.
  - `stat_conflict` >= 3.
  - `stat_grant0` + `stat_grant1` equals the total number of transactions.
